// File: rtl/mar_burst_pkg.sv
// Shared types and helpers for the BitCruncher memory address register burst unit.
// Imported by the interface, the beat counter and the top.
package mar_burst_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } mar_state_e;

    typedef enum logic [1:0] {
        SRC_HOLD = 2'd0,
        SRC_MBR  = 2'd1,
        SRC_IDX  = 2'd2,
        SRC_PC   = 2'd3
    } load_src_e;

    // Beat-count width; never below 1 so a single-beat configuration still has a counter bit.
    function automatic int blw_of(input int max_burst);
        return (max_burst <= 2) ? 1 : $clog2(max_burst);
    endfunction

endpackage

// File: rtl/mar_burst_unit_if.sv
// Control-unit strobes and memory-port handshake of the burst unit, plus a state debug tap.
// Handshake: a beat is transferred on a rising edge where mem_req and mem_ack are both high; mem_req never drops while a beat is pending.
interface mar_burst_unit_if #(
    parameter int AW  = 8,
    parameter int DW  = 16,
    parameter int BLW = 2
);
    import mar_burst_pkg::*;

    logic           ld_mbr;
    logic           ld_idx;
    logic           ld_pc;
    logic [DW-1:0]  mbr_in;
    logic [AW-1:0]  pc_in;
    logic [AW-1:0]  idx_base_in;
    logic           burst_start;
    logic [BLW-1:0] burst_len;
    logic           burst_abort;
    logic           mem_ack;
    logic           clr_wrap;
    logic [AW-1:0]  mar_out;
    logic           mem_req;
    logic           busy;
    logic           burst_done;
    logic           wrap_flag;
    mar_state_e     state_dbg;

    modport slave (
        input  ld_mbr, ld_idx, ld_pc, mbr_in, pc_in, idx_base_in,
        input  burst_start, burst_len, burst_abort, mem_ack, clr_wrap,
        output mar_out, mem_req, busy, burst_done, wrap_flag, state_dbg
    );

    modport master (
        output ld_mbr, ld_idx, ld_pc, mbr_in, pc_in, idx_base_in,
        output burst_start, burst_len, burst_abort, mem_ack, clr_wrap,
        input  mar_out, mem_req, busy, burst_done, wrap_flag, state_dbg
    );

endinterface

// File: rtl/mar_beat_counter.sv
// Remaining-beat counter: loads beats-minus-one at burst start, decrements per accepted beat.
// zero marks the final beat of the burst.
module mar_beat_counter #(
    parameter int BLW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [BLW-1:0] load_val,
    input  logic           dec,
    output logic           zero
);
    logic [BLW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - BLW'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mar_burst_unit.sv
// Memory address register with MBR/indexed/PC loads and auto-incrementing req/ack bursts.
// All outputs come straight from registers; no input reaches an output combinationally.
module mar_burst_unit
    import mar_burst_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    mar_burst_unit_if.slave  bus
);
    localparam int BLW = blw_of(MAX_BURST);

    mar_state_e     state_q, state_d;
    load_src_e      src;
    logic [AW-1:0]  mar_q, mar_d, load_addr;
    logic [AW:0]    idx_sum;
    logic [BLW-1:0] len_clamped;
    logic           wrap_q, set_wrap;
    logic           done_q, done_d;
    logic           cnt_load, cnt_dec, cnt_zero;
    logic           unused_mbr_hi;

    assign unused_mbr_hi = ^bus.mbr_in[DW-1:AW];

    always_comb begin
        src = SRC_HOLD;
        if (bus.ld_mbr) begin
            src = SRC_MBR;
        end else if (bus.ld_idx) begin
            src = SRC_IDX;
        end else if (bus.ld_pc) begin
            src = SRC_PC;
        end
    end

    // One extra bit so the carry out of the indexed add can flag a wrap.
    assign idx_sum = {1'b0, bus.idx_base_in} + {1'b0, bus.mbr_in[AW-1:0]};

    always_comb begin
        load_addr = mar_q;
        unique case (src)
            SRC_MBR:  load_addr = bus.mbr_in[AW-1:0];
            SRC_IDX:  load_addr = idx_sum[AW-1:0];
            SRC_PC:   load_addr = bus.pc_in;
            default:  load_addr = mar_q;
        endcase
    end

    always_comb begin
        len_clamped = bus.burst_len;
        if ({{(32-BLW){1'b0}}, bus.burst_len} >= 32'(MAX_BURST)) begin
            len_clamped = BLW'(MAX_BURST - 1);
        end
    end

    always_comb begin
        state_d  = state_q;
        mar_d    = mar_q;
        set_wrap = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                mar_d    = load_addr;
                set_wrap = (src == SRC_IDX) && idx_sum[AW];
                if (bus.burst_start) begin
                    state_d  = BURST;
                    cnt_load = 1'b1;
                end
            end
            BURST: begin
                // Abort outranks ack, so the acked beat does not advance the address.
                if (bus.burst_abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (bus.mem_ack) begin
                    if (cnt_zero) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        mar_d    = mar_q + AW'(1);
                        cnt_dec  = 1'b1;
                        set_wrap = &mar_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mar_q   <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            done_q  <= done_d;
            if (set_wrap) begin
                wrap_q <= 1'b1;
            end else if (bus.clr_wrap) begin
                wrap_q <= 1'b0;
            end
        end
    end

    mar_beat_counter #(
        .BLW (BLW)
    ) u_beat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (len_clamped),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign bus.mar_out    = mar_q;
    assign bus.mem_req    = (state_q == BURST);
    assign bus.busy       = (state_q == BURST);
    assign bus.burst_done = done_q;
    assign bus.wrap_flag  = wrap_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_mar_burst_unit.sv
// Bench for mar_burst_unit: directed loads plus bursts checked against a queue of expected beat addresses.
module tb_mar_burst_unit;
    import mar_burst_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mar_burst_unit_if #(.AW(8), .DW(16), .BLW(2)) bus ();

    mar_burst_unit #(
        .AW        (8),
        .DW        (16),
        .MAX_BURST (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         total    = 0;
    int         bad      = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ld_mbr      = 1'b0;
        bus.ld_idx      = 1'b0;
        bus.ld_pc       = 1'b0;
        bus.burst_start = 1'b0;
        bus.burst_abort = 1'b0;
        bus.clr_wrap    = 1'b0;
        bus.mem_ack     = 1'b0;
    endtask

    // Scoreboard: every accepted (non-aborted) beat must present the next expected address.
    always @(negedge clk) begin
        logic [7:0] exp_addr;
        if (!rst && bus.burst_done) done_cnt++;
        if (!rst && bus.mem_req && bus.mem_ack && !bus.burst_abort) begin
            if (exp_q.size() == 0) begin
                check("beat_q_size", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_addr = exp_q.pop_front();
                check("beat_addr", {24'd0, bus.mar_out}, {24'd0, exp_addr});
            end
        end
    end

    // Starts a burst via ld_pc+burst_start and returns at the first negedge with mem_req low.
    task automatic run_burst(input logic [7:0] start, input logic [1:0] len, input bit alt,
                             output int req_cycles);
        bit finished;
        bus.ld_pc       = 1'b1;
        bus.pc_in       = start;
        bus.burst_start = 1'b1;
        bus.burst_len   = len;
        bus.mem_ack     = alt ? 1'b0 : 1'b1;
        for (int i = 0; i <= int'(len); i++) exp_q.push_back(start + 8'(i));
        step();
        bus.ld_pc       = 1'b0;
        bus.burst_start = 1'b0;
        req_cycles = 0;
        finished   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.mem_req) begin
                finished = 1'b1;
                break;
            end
            req_cycles++;
            @(posedge clk);
            #1;
            if (alt) bus.mem_ack = ~bus.mem_ack;
        end
        check("burst_ends", {31'd0, finished}, 32'd1);
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        int req;
        int done_before;
        clear_inputs();
        bus.mbr_in      = '0;
        bus.pc_in       = '0;
        bus.idx_base_in = '0;
        bus.burst_len   = '0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mar", {24'd0, bus.mar_out}, 32'h00);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_wrap", {31'd0, bus.wrap_flag}, 32'd0);
        check("rst_done", {31'd0, bus.burst_done}, 32'd0);

        // ld_mbr beats ld_pc; upper MBR byte ignored
        bus.ld_mbr = 1'b1; bus.ld_pc = 1'b1; bus.mbr_in = 16'hAB3C; bus.pc_in = 8'h10;
        step(); clear_inputs();
        @(negedge clk);
        check("prio_mbr_pc", {24'd0, bus.mar_out}, 32'h3C);

        bus.ld_idx = 1'b1; bus.ld_pc = 1'b1; bus.idx_base_in = 8'h05; bus.mbr_in = 16'h0003;
        step(); clear_inputs();
        @(negedge clk);
        check("prio_idx_pc", {24'd0, bus.mar_out}, 32'h08);
        check("idx_nowrap", {31'd0, bus.wrap_flag}, 32'd0);

        bus.ld_idx = 1'b1; bus.idx_base_in = 8'hF0; bus.mbr_in = 16'h0020;
        step(); clear_inputs();
        @(negedge clk);
        check("idx_wrap_mar", {24'd0, bus.mar_out}, 32'h10);
        check("idx_wrap_flag", {31'd0, bus.wrap_flag}, 32'd1);

        bus.clr_wrap = 1'b1;
        step(); clear_inputs();
        @(negedge clk);
        check("clr_wrap", {31'd0, bus.wrap_flag}, 32'd0);

        // set and clear together: set wins
        bus.ld_idx = 1'b1; bus.clr_wrap = 1'b1;
        step(); clear_inputs();
        @(negedge clk);
        check("wrap_set_wins", {31'd0, bus.wrap_flag}, 32'd1);
        bus.clr_wrap = 1'b1;
        step(); clear_inputs();

        // ack/abort in IDLE ignored, MAR holds without a load
        bus.mem_ack = 1'b1; bus.burst_abort = 1'b1;
        step(); clear_inputs();
        @(negedge clk);
        check("idle_hold_mar", {24'd0, bus.mar_out}, 32'h10);
        check("idle_ign_busy", {31'd0, bus.busy}, 32'd0);
        check("idle_ign_done", {31'd0, bus.burst_done}, 32'd0);

        done_before = done_cnt;
        run_burst(8'h40, 2'd3, 1'b0, req);
        check("full_req_cycles", 32'(req), 32'd4);
        check("full_done", {31'd0, bus.burst_done}, 32'd1);
        check("full_busy", {31'd0, bus.busy}, 32'd0);
        check("full_mar", {24'd0, bus.mar_out}, 32'h43);
        check("full_wrap", {31'd0, bus.wrap_flag}, 32'd0);
        step();
        @(negedge clk);
        check("full_done_once", 32'(done_cnt - done_before), 32'd1);
        check("full_done_drop", {31'd0, bus.burst_done}, 32'd0);

        run_burst(8'h50, 2'd0, 1'b0, req);
        check("single_req_cycles", 32'(req), 32'd1);
        check("single_mar", {24'd0, bus.mar_out}, 32'h50);

        run_burst(8'hFE, 2'd2, 1'b1, req);
        check("stall_req_cycles", 32'(req), 32'd6);
        check("stall_mar", {24'd0, bus.mar_out}, 32'h00);
        check("stall_wrap", {31'd0, bus.wrap_flag}, 32'd1);
        check("stall_done", {31'd0, bus.burst_done}, 32'd1);
        bus.clr_wrap = 1'b1;
        step(); clear_inputs();

        // abort with simultaneous ack; ld_mbr inside the burst is ignored
        done_before = done_cnt;
        bus.ld_pc = 1'b1; bus.pc_in = 8'h20; bus.burst_start = 1'b1; bus.burst_len = 2'd3;
        exp_q.push_back(8'h20);
        step(); clear_inputs();
        bus.mem_ack = 1'b1;
        step(); clear_inputs();
        bus.ld_mbr = 1'b1; bus.mbr_in = 16'h0077;
        @(negedge clk);
        check("abort_mid_mar", {24'd0, bus.mar_out}, 32'h21);
        step(); clear_inputs();
        @(negedge clk);
        check("abort_ld_ignored", {24'd0, bus.mar_out}, 32'h21);
        check("abort_still_busy", {31'd0, bus.busy}, 32'd1);
        bus.burst_abort = 1'b1; bus.mem_ack = 1'b1;
        step(); clear_inputs();
        @(negedge clk);
        check("abort_mar", {24'd0, bus.mar_out}, 32'h21);
        check("abort_state", {31'd0, bus.state_dbg == IDLE}, 32'd1);
        check("abort_req", {31'd0, bus.mem_req}, 32'd0);
        check("abort_done", {31'd0, bus.burst_done}, 32'd1);
        step();
        check("abort_done_once", 32'(done_cnt - done_before), 32'd1);

        // reset mid-burst: no done pulse
        done_before = done_cnt;
        bus.ld_pc = 1'b1; bus.pc_in = 8'h30; bus.burst_start = 1'b1; bus.burst_len = 2'd3;
        step(); clear_inputs();
        @(negedge clk);
        check("rstb_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rstb_req", {31'd0, bus.mem_req}, 32'd0);
        check("rstb_mar", {24'd0, bus.mar_out}, 32'h00);
        check("rstb_done", {31'd0, bus.burst_done}, 32'd0);
        step();
        @(negedge clk);
        check("rstb_no_done", {31'd0, bus.burst_done}, 32'd0);
        step();
        check("rstb_done_cnt", 32'(done_cnt - done_before), 32'd0);

        check("beats_consumed", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mar_burst_unit.md
Name: mar_burst_unit

Overview:
- Parametrised memory address register for the BitCruncher datapath.
- Loads the address from the MBR address field, the PC, or an indexed sum (base + MBR field).
- Runs multi-word memory bursts with auto-increment and a req/ack handshake to memory.
- Sits between the control unit (load strobes) and the memory port (mar_out, mem_req/mem_ack).

Parameters:
- AW, 8, address width; also the width of mar_out, pc_in and idx_base_in.
- DW, 16, MBR width; the address field is mbr_in[AW-1:0].
- MAX_BURST, 4, maximum beats per burst; BLW = clog2(MAX_BURST).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_mbr  in  1  load MAR from mbr_in[AW-1:0].
- ld_idx  in  1  load MAR from idx_base_in + mbr_in[AW-1:0].
- ld_pc  in  1  load MAR from pc_in.
- mbr_in  in  DW  memory buffer register contents.
- pc_in  in  AW  program counter.
- idx_base_in  in  AW  index base register.
- burst_start  in  1  begin a burst at the current or just-loaded address.
- burst_len  in  BLW  beats minus 1; sampled only on an accepted burst_start.
- burst_abort  in  1  terminate the active burst.
- mem_ack  in  1  memory accepted the current beat.
- clr_wrap  in  1  clear wrap_flag.
- mar_out  out  AW  current address, registered.
- mem_req  out  1  beat request; high in BURST.
- busy  out  1  high in BURST.
- burst_done  out  1  one-cycle pulse after the final beat or an abort.
- wrap_flag  out  1  sticky; address arithmetic crossed 2^AW.

Behaviour:
- Reset (synchronous, active-high): mar_out=0, state=IDLE, beat counter=0, mem_req=0, busy=0, burst_done=0, wrap_flag=0. Reset mid-burst drops mem_req the next cycle with no burst_done pulse.
- States: IDLE, BURST. busy and mem_req are decoded from the state register, so there is no combinational path from inputs to outputs.
- IDLE loads take effect at the next edge, priority ld_mbr > ld_idx > ld_pc. With no load asserted, MAR holds.
- Load widths: ld_mbr uses mbr_in[AW-1:0]; upper MBR bits are ignored.
- Indexed load: ld_idx computes an AW+1-bit sum and keeps the low AW bits. A carry-out sets wrap_flag.
- IDLE and burst_start: go to BURST and set counter=burst_len.
  - If a load is asserted in the same cycle, the burst starts at the loaded address.
  - mem_req is first high the cycle after burst_start.
- BURST, no mem_ack: all state holds and mem_req stays high (the memory may stall indefinitely).
- BURST, mem_ack with counter != 0: mar_out <= mar_out+1 (mod 2^AW) and counter decrements. An FF..F -> 0 increment sets wrap_flag.
- BURST, mem_ack with counter == 0: go to IDLE, mar_out holds the last beat address, and burst_done pulses the following cycle.
- Latency: a burst of N beats with ack every cycle takes N cycles of mem_req.
- Ignored inputs:
  - Loads and burst_start in BURST are ignored, not queued.
  - mem_ack and burst_abort in IDLE are ignored.
- burst_abort in BURST: go to IDLE next cycle and mar_out holds. It has priority over a simultaneous mem_ack, so that beat does not advance the address. burst_done pulses.
- burst_len: values >= MAX_BURST are clamped to MAX_BURST-1.
- wrap_flag: sticky until clr_wrap or rst. If set and clear occur in the same cycle, set wins.

Decomposition:
- Package mar_burst_pkg:
  - State enum {IDLE, BURST}.
  - Load-source select encoding {SRC_HOLD, SRC_MBR, SRC_IDX, SRC_PC}.
  - BLW derivation function.
- Sub-module mar_beat_counter: load, decrement-on-ack and zero-detect for the beat count.
- The top holds the FSM, the address mux/adder and the flags.

Test Plan:
- Reset and load priority: rst=1 for 2 cycles, then mar_out=0x00 and busy=0. Assert ld_mbr=1, ld_pc=1, mbr_in=0xAB3C, pc_in=0x10 in one cycle -> mar_out=0x3C next cycle.
- Indexed wrap: idx_base_in=0xF0, mbr_in=0x0020, ld_idx=1 -> mar_out=0x10 and wrap_flag=1. Then clr_wrap=1 -> wrap_flag=0.
- Full burst: ld_pc with pc_in=0x40 plus burst_start, burst_len=3, mem_ack always 1 -> mem_req high 4 cycles, mar_out 0x40,0x41,0x42,0x43, burst_done pulse once, busy=0.
- Stalled burst across wrap: start at 0xFE, burst_len=2, mem_ack alternating 0/1 -> mar_out 0xFE,0xFE,0xFF,0xFF,0x00, wrap_flag=1, mem_req held during stalls.
- Abort and ignored loads: burst from 0x20 with burst_len=3. After 1 ack, ld_mbr=1 (ignored), then burst_abort=1 together with mem_ack=1 -> mar_out stays 0x21, state IDLE, burst_done pulse.
- Reset mid-burst: rst=1 during BURST -> next cycle mem_req=0, mar_out=0x00, no burst_done pulse.
